// File: rtl/sensor_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sensor_stream_arbiter
// Purpose  : Per-channel sample FIFOs merged round-robin into 32-bit UART words.
//            Define SENSOR_STREAM_TIMESTAMP_EN to append a cycle-count word.
// Revision : 1.0 - initial release
// ============================================================================
module sensor_stream_arbiter #(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     i_CLK,
  input  logic                     i_RST,
  input  logic [NUM_CH*DATA_W-1:0] i_CH_DATA,
  input  logic [NUM_CH-1:0]        i_CH_VALID,
  input  logic [NUM_CH-1:0]        i_CH_ENABLE,
  input  logic                     i_OVF_CLR,
  output logic [31:0]              o_UART_DATA_TX,
  output logic                     o_UART_DATA_TX_VALID,
  input  logic                     i_UART_DATA_TX_READY,
  output logic [NUM_CH-1:0]        o_OVERFLOW,
  output logic                     o_BUSY
);

  localparam int              PTR_W    = $clog2(FIFO_DEPTH);
  localparam int              CH_W     = $clog2(NUM_CH);
  localparam int              ENT_W    = 5 + DATA_W;
  localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HOLD    = 2'd1;
`ifdef SENSOR_STREAM_TIMESTAMP_EN
  localparam logic [1:0] S_HOLD_TS = 2'd2;
  localparam logic [1:0] S_LAST    = S_HOLD_TS;
`else
  localparam logic [1:0] S_LAST    = S_HOLD;
`endif

  logic [NUM_CH-1:0]            w_nonempty;
  logic [NUM_CH-1:0]            w_avail;
  logic [NUM_CH-1:0]            w_pop;
  logic [NUM_CH-1:0][ENT_W-1:0] w_head;
  logic                         w_pop_en;
  logic                         w_win_valid;
  logic [CH_W-1:0]              w_win_ch;
  logic [31:0]                  w_win_word;

  logic [1:0]      state_q, state_d;
  logic [CH_W-1:0] last_q, last_d;
  logic [31:0]     word_q, word_d;

`ifdef SENSOR_STREAM_TIMESTAMP_EN
  logic [31:0]             ts_q;
  logic [NUM_CH-1:0][31:0] w_ts_cur;

  always_ff @(posedge i_CLK) begin
    if (i_RST) ts_q <= '0;
    else       ts_q <= ts_q + 32'd1;
  end
`endif

  // The final word of a grant pops its FIFO entry on acceptance.
  assign w_pop_en = i_UART_DATA_TX_READY & (state_q == S_LAST);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, head_ptr;
    logic [PTR_W:0]   count_q;
    logic [4:0]       seq_q;
    logic             ovf_q, strobe, full, push;

    assign strobe         = i_CH_VALID[k] & i_CH_ENABLE[k];
    assign full           = (count_q == CNT_FULL);
    assign push           = strobe & ~full;
    assign w_pop[k]       = w_pop_en & (last_q == CH_W'(k));
    assign head_ptr       = rd_ptr_q + PTR_W'(w_pop[k]);
    assign w_nonempty[k]  = (count_q != '0);
    // Availability as seen after this edge's pop, enabling back-to-back words.
    assign w_avail[k]     = w_pop[k] ? (count_q > (PTR_W+1)'(1)) : w_nonempty[k];
    assign w_head[k]      = mem_q[head_ptr];
    assign o_OVERFLOW[k]  = ovf_q;

    always_ff @(posedge i_CLK) begin
      if (push) mem_q[wr_ptr_q] <= {seq_q, i_CH_DATA[k*DATA_W +: DATA_W]};
    end

`ifdef SENSOR_STREAM_TIMESTAMP_EN
    logic [31:0] ts_mem_q [FIFO_DEPTH];
    assign w_ts_cur[k] = ts_mem_q[rd_ptr_q];
    always_ff @(posedge i_CLK) begin
      if (push) ts_mem_q[wr_ptr_q] <= ts_q;
    end
`endif

    always_ff @(posedge i_CLK) begin
      if (i_RST) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        seq_q    <= '0;
        ovf_q    <= 1'b0;
      end else begin
        if (push)     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (w_pop[k]) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        if (push && !w_pop[k])      count_q <= count_q + (PTR_W+1)'(1);
        else if (!push && w_pop[k]) count_q <= count_q - (PTR_W+1)'(1);
        if (strobe) seq_q <= seq_q + 5'd1;
        if (strobe && full)  ovf_q <= 1'b1;
        else if (i_OVF_CLR)  ovf_q <= 1'b0;
      end
    end
  end

  function automatic logic [CH_W-1:0] f_wrap_add(input logic [CH_W-1:0] base,
                                                 input logic [CH_W:0]   off);
    logic [CH_W+1:0] s;
    s = {2'b00, base} + {1'b0, off};
    if (s >= (CH_W+2)'(NUM_CH)) s = s - (CH_W+2)'(NUM_CH);
    return s[CH_W-1:0];
  endfunction

  // Round-robin: the lowest offset after the last grant wins.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_ch    = '0;
    for (int i = NUM_CH; i >= 1; i--) begin
      if (w_avail[f_wrap_add(last_q, (CH_W+1)'(i))]) begin
        w_win_valid = 1'b1;
        w_win_ch    = f_wrap_add(last_q, (CH_W+1)'(i));
      end
    end
  end

  assign w_win_word = {3'(w_win_ch), w_head[w_win_ch][ENT_W-1 -: 5],
                       24'(w_head[w_win_ch][DATA_W-1:0])};

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      last_q  <= CH_W'(NUM_CH - 1);
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE: if (w_win_valid) state_d = S_HOLD;
`ifdef SENSOR_STREAM_TIMESTAMP_EN
      S_HOLD: begin
        if (i_UART_DATA_TX_READY) begin
          state_d = S_HOLD_TS;
          word_d  = w_ts_cur[last_q];
        end
      end
`endif
      default: ;
    endcase
    if (w_pop_en) state_d = w_win_valid ? S_HOLD : S_IDLE;
    if ((state_q == S_IDLE || w_pop_en) && w_win_valid) begin
      last_d = w_win_ch;
      word_d = w_win_word;
    end
  end

  always_comb begin
    o_UART_DATA_TX       = word_q;
    o_UART_DATA_TX_VALID = (state_q != S_IDLE);
    o_BUSY               = (|w_nonempty) | (state_q != S_IDLE);
  end

endmodule
`default_nettype wire

// File: tb/tb_sensor_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_stream_arbiter
// Purpose  : Directed vector table plus streaming sequences for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sensor_stream_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] ch_data = '0;
  logic [1:0]  ch_valid = '0;
  logic [1:0]  ch_enable = 2'b11;
  logic        ovf_clr = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic [1:0]  overflow;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  sensor_stream_arbiter #(.NUM_CH(2), .DATA_W(24), .FIFO_DEPTH(4)) dut (
    .i_CLK                (clk),
    .i_RST                (rst),
    .i_CH_DATA            (ch_data),
    .i_CH_VALID           (ch_valid),
    .i_CH_ENABLE          (ch_enable),
    .i_OVF_CLR            (ovf_clr),
    .o_UART_DATA_TX       (tx_data),
    .o_UART_DATA_TX_VALID (tx_valid),
    .i_UART_DATA_TX_READY (ready),
    .o_OVERFLOW           (overflow),
    .o_BUSY               (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [1:0]  vld;
    logic [1:0]  en;
    logic [23:0] d0;
    logic [23:0] d1;
    logic        clr;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eo;
    logic        eb;
    logic        cd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [1:0] vld, input logic [1:0] en,
                     input logic [23:0] d0, input logic [23:0] d1, input logic clr,
                     input logic rdy, input logic ev, input logic [31:0] ed,
                     input logic [1:0] eo, input logic eb, input logic cd);
    vec_t v;
    v.rst = r; v.vld = vld; v.en = en; v.d0 = d0; v.d1 = d1; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.eo = eo; v.eb = eb; v.cd = cd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic stream(input int ch, input int n, input int seq0, input logic [23:0] base);
    logic [31:0] exp;
    int got = 0;
    for (int c = 0; c < n + 10; c++) begin
      ch_valid = '0;
      if (c < n) begin
        ch_valid[ch] = 1'b1;
        ch_data[ch*24 +: 24] = base + 24'(c);
      end
      step();
      ch_valid = '0;
      if (tx_valid && got < n) begin
        exp = {3'(ch), 5'((seq0 + got) % 32), base + 24'(got)};
        chk($sformatf("stream ch%0d word%0d", ch, got), tx_data, exp);
        got++;
      end
    end
    chk($sformatf("stream ch%0d count", ch), 32'(got), 32'(n));
    chk($sformatf("stream ch%0d busy", ch), 32'(busy), 32'd0);
  endtask

  initial begin
`ifdef SENSOR_STREAM_TIMESTAMP_EN
    step();
    rst = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    ch_valid = 2'b11;
    ch_data  = {24'h0000BB, 24'h0000AA};
    step();
    ch_valid = '0;
    chk("ts push valid", 32'(tx_valid), 32'd0);
    step();
    chk("ts w0 valid", 32'(tx_valid), 32'd1);
    chk("ts w0 data", tx_data, 32'h000000AA);
    step();
    chk("ts w1 valid", 32'(tx_valid), 32'd1);
    chk("ts w1 data", tx_data, 32'h00000010);
    step();
    chk("ts w2 data", tx_data, 32'h200000BB);
    step();
    chk("ts w3 data", tx_data, 32'h00000010);
    step();
    chk("ts idle valid", 32'(tx_valid), 32'd0);
    chk("ts idle busy", 32'(busy), 32'd0);
`else
    // Reset state
    add(1,0,3,0,0,0,1, 0,0,0,0,1);
    add(1,0,3,0,0,0,1, 0,0,0,0,1);
    // Single push latency
    add(0,1,3,24'h123456,0,0,1, 0,0,0,1,0);
    add(0,0,3,0,0,0,1, 1,32'h00123456,0,1,1);
    add(0,0,3,0,0,0,1, 0,0,0,0,0);
    // ch1 primer, then simultaneous strobes
    add(1,0,3,0,0,0,1, 0,0,0,0,1);
    add(0,2,3,0,24'hABCDEF,0,1, 0,0,0,1,0);
    add(0,0,3,0,0,0,1, 1,32'h20ABCDEF,0,1,1);
    add(0,0,3,0,0,0,1, 0,0,0,0,0);
    add(0,3,3,24'h1,24'h2,0,1, 0,0,0,1,0);
    add(0,0,3,0,0,0,1, 1,32'h00000001,0,1,1);
    add(0,0,3,0,0,0,1, 1,32'h21000002,0,1,1);
    add(0,0,3,0,0,0,1, 0,0,0,0,0);
    // Stall ten cycles, then round-robin drain
    add(0,3,3,24'hA0,24'hB0,0,0, 0,0,0,1,0);
    add(0,1,3,24'hA1,0,0,0, 1,32'h010000A0,0,1,1);
    for (int i = 0; i < 9; i++) add(0,0,3,0,0,0,0, 1,32'h010000A0,0,1,1);
    add(0,0,3,0,0,0,1, 1,32'h220000B0,0,1,1);
    add(0,0,3,0,0,0,1, 1,32'h020000A1,0,1,1);
    add(0,0,3,0,0,0,1, 0,0,0,0,0);
    // Overflow on ch1
    add(1,0,3,0,0,0,1, 0,0,0,0,1);
    add(0,2,3,0,24'h10,0,0, 0,0,0,1,0);
    add(0,2,3,0,24'h11,0,0, 1,32'h20000010,0,1,1);
    add(0,2,3,0,24'h12,0,0, 1,32'h20000010,0,1,1);
    add(0,2,3,0,24'h13,0,0, 1,32'h20000010,0,1,1);
    add(0,2,3,0,24'h14,0,0, 1,32'h20000010,2,1,1);
    add(0,2,3,0,24'h15,0,0, 1,32'h20000010,2,1,1);
    add(0,0,3,0,0,0,1, 1,32'h21000011,2,1,1);
    add(0,0,3,0,0,0,1, 1,32'h22000012,2,1,1);
    add(0,0,3,0,0,0,1, 1,32'h23000013,2,1,1);
    add(0,0,3,0,0,0,1, 0,0,2,0,0);
    add(0,2,3,0,24'h99,0,1, 0,0,2,1,0);
    add(0,0,3,0,0,0,1, 1,32'h26000099,2,1,1);
    add(0,0,3,0,0,0,1, 0,0,2,0,0);
    // Overflow clear vs simultaneous overflow
    add(0,2,3,0,24'h20,0,0, 0,0,2,1,0);
    add(0,2,3,0,24'h21,0,0, 1,32'h27000020,2,1,1);
    add(0,2,3,0,24'h22,0,0, 1,32'h27000020,2,1,1);
    add(0,2,3,0,24'h23,0,0, 1,32'h27000020,2,1,1);
    add(0,2,3,0,24'h24,1,0, 1,32'h27000020,2,1,1);
    add(0,0,3,0,0,1,0, 1,32'h27000020,0,1,1);
    add(0,2,3,0,24'h25,0,0, 1,32'h27000020,2,1,1);
    add(0,1,3,24'h55,0,1,0, 1,32'h27000020,0,1,1);
    add(0,0,3,0,0,0,1, 1,32'h00000055,0,1,1);
    // Reset while holding with entries queued
    add(1,0,3,0,0,0,1, 0,0,0,0,1);
    add(0,0,3,0,0,0,1, 0,0,0,0,0);
    add(0,1,3,24'h777,0,0,1, 0,0,0,1,0);
    add(0,0,3,0,0,0,1, 1,32'h00000777,0,1,1);
    add(0,0,3,0,0,0,1, 0,0,0,0,0);
    // Disabled channels still drain, and their strobes are not counted
    add(0,3,3,24'hC0,24'hD0,0,0, 0,0,0,1,0);
    add(0,3,0,24'hC8,24'hD8,0,0, 1,32'h200000D0,0,1,1);
    add(0,3,0,24'hC9,24'hD9,0,1, 1,32'h010000C0,0,1,1);
    add(0,1,0,24'hCA,0,0,1, 0,0,0,0,0);
    add(0,1,3,24'hC1,0,0,1, 0,0,0,1,0);
    add(0,0,3,0,0,0,1, 1,32'h020000C1,0,1,1);
    add(0,0,3,0,0,0,1, 0,0,0,0,0);

    foreach (tbl[i]) begin
      rst       = tbl[i].rst;
      ch_valid  = tbl[i].vld;
      ch_enable = tbl[i].en;
      ch_data   = {tbl[i].d1, tbl[i].d0};
      ovf_clr   = tbl[i].clr;
      ready     = tbl[i].rdy;
      step();
      chk($sformatf("v%0d valid", i), 32'(tx_valid), 32'(tbl[i].ev));
      chk($sformatf("v%0d ovf", i), 32'(overflow), 32'(tbl[i].eo));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'(tbl[i].eb));
      if (tbl[i].cd) chk($sformatf("v%0d data", i), tx_data, tbl[i].ed);
    end

    rst = 1'b0; ch_valid = '0; ch_enable = 2'b11; ovf_clr = 1'b0; ready = 1'b1;
    // Continuous streams: back-to-back output, and ch1 sequence wrap 31->0
    stream(0, 8, 3, 24'h100000);
    stream(1, 40, 1, 24'h200000);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sensor_stream_arbiter.md
SENSOR_STREAM_ARBITER -- requirements
Module: sensor_stream_arbiter

Interface
- REQ-001 SHALL have parameter NUM_CH, 2, number of sensor channels (legal 2..8).
- REQ-002 SHALL have parameter DATA_W, 24, sample width per channel (legal 1..24).
- REQ-003 SHALL have parameter FIFO_DEPTH, 4, per-channel FIFO entries (power of two, 2..16).
- REQ-004 SHALL use one clock, i_CLK; reset i_RST is synchronous and active-high.
- REQ-005 i_CLK  input  1  system clock.
- REQ-006 i_RST  input  1  synchronous active-high reset.
- REQ-007 i_CH_DATA  input  NUM_CH*DATA_W  channel k sample at bits [k*DATA_W +: DATA_W].
- REQ-008 i_CH_VALID  input  NUM_CH  one-cycle sample strobe per channel.
- REQ-009 i_CH_ENABLE  input  NUM_CH  channel k accepts samples when high.
- REQ-010 i_OVF_CLR  input  1  pulse that clears all overflow flags.
- REQ-011 o_UART_DATA_TX  output  32  word toward the UART controller.
- REQ-012 o_UART_DATA_TX_VALID  output  1  word valid.
- REQ-013 i_UART_DATA_TX_READY  input  1  UART accepts the word.
- REQ-014 o_OVERFLOW  output  NUM_CH  sticky per-channel drop flag.
- REQ-015 o_BUSY  output  1  any FIFO non-empty or output word pending.

Function
- REQ-016 Push: i_CH_VALID[k] & i_CH_ENABLE[k] & FIFO k not full (value at start of cycle) SHALL write the sample to FIFO k at that edge.
- REQ-017 Full FIFO SHALL drop the sample, set o_OVERFLOW[k] at the same edge, and leave FIFO contents unchanged; same-cycle pop does not rescue it.
- REQ-018 Each channel SHALL keep a 5-bit sequence counter incremented on every enabled strobe, dropped or not, wrapping 31->0; it is stored with the sample.
- REQ-019 Word format SHALL be [31:29] channel index, [28:24] sequence, [23:0] sample zero-extended.
- REQ-020 Output stage states: IDLE (valid low) and HOLD (valid high); data and valid SHALL stay stable in HOLD until i_UART_DATA_TX_READY is high.
- REQ-021 IDLE->HOLD SHALL occur on the edge after any FIFO is non-empty; a sample pushed at edge E into an empty system is presented with valid high after edge E+1.
- REQ-022 HOLD with ready high SHALL pop the next winner in the same edge (back-to-back, one word per cycle) or return to IDLE if all FIFOs are empty.
- REQ-023 Arbitration SHALL be round-robin: search starts at the channel after the last granted, wrapping NUM_CH-1->0.
- REQ-024 Disabling a channel SHALL stop pushes only; queued samples still drain.
- REQ-025 i_OVF_CLR SHALL clear o_OVERFLOW; a new overflow in the same cycle wins (flag stays 1).
- REQ-026 o_BUSY SHALL be registered-derived: OR of FIFO non-empty flags and o_UART_DATA_TX_VALID.

Reset
- REQ-027 On i_RST high at an edge: FIFOs empty, pointers 0, sequence counters 0, o_OVERFLOW 0, o_UART_DATA_TX 0, o_UART_DATA_TX_VALID 0, o_BUSY 0, state IDLE, round-robin pointer such that channel 0 wins first, timestamp counter 0.
- REQ-028 Reset mid-transfer SHALL discard the held word and all queued samples; valid is low after that edge.

Configuration
- REQ-029 Macro SENSOR_STREAM_TIMESTAMP_EN: when defined, a free-running 32-bit cycle counter (wrapping) is captured with each pushed sample and each grant emits two words, sample word then timestamp word, with no other channel interleaved; the FIFO pop occurs when the second word is accepted.
- REQ-030 Without SENSOR_STREAM_TIMESTAMP_EN: no counter, no extra FIFO storage, one word per sample.

Verification (NUM_CH=2, DATA_W=24, FIFO_DEPTH=4, ready held high unless stated)
- REQ-031 Single push ch0 0x123456 at edge E -> valid high after E+1, word 0x00123456, valid low next cycle.
- REQ-032 Same-cycle strobes ch0 0x000001, ch1 0x000002 -> words 0x00000001 then 0x21000002 on consecutive cycles.
- REQ-033 Ready low, 6 strobes on ch1 -> 4 stored, o_OVERFLOW=2'b10; after ready high, sequences 0,1,2,3 emitted; next accepted sample carries sequence 6.
- REQ-034 Ready low for 10 cycles while valid -> o_UART_DATA_TX unchanged; i_OVF_CLR with simultaneous overflow -> flag stays 1.
- REQ-035 Reset asserted while HOLD with 3 queued -> next cycle valid 0, o_BUSY 0, next push emits sequence 0.
- REQ-036 With SENSOR_STREAM_TIMESTAMP_EN, push ch0 at counter 0x00000010 -> sample word then 0x00000010; ch1 word follows only afterwards.
